// File: rtl/axis_pkt_arbiter.sv
// Packet-granular AXI-Stream arbiter: one grant is held from the first beat to tlast.
// Define AXIS_ARB_STRICT_PRIORITY_EN for fixed lowest-index-wins arbitration (default is round-robin).
module axis_pkt_arbiter #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int NUM_PORTS      = 2,
  parameter int PORT_ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                                m_aclk,
  input  logic                                m_areset,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  output logic [NUM_PORTS-1:0]                s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_trdy,
  output logic [PORT_ID_W-1:0]                grant_id,
  output logic                                busy
);

  // Handshake: a beat moves when tvalid & trdy are both high at a rising edge;
  // trdy of the granted port is a pure copy of m_axis_trdy, every other trdy is 0.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PORT_ID_W-1:0] grant_q, grant_d;
  logic [PORT_ID_W-1:0] pick;
  logic                 eop_beat;

`ifdef AXIS_ARB_STRICT_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) pick = PORT_ID_W'(i);
    end
  end
`else
  logic [PORT_ID_W-1:0] last_grant_q, last_grant_d;
  logic [PORT_ID_W-1:0] pick_hi, pick_lo;
  logic                 found_hi;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        pick_lo = PORT_ID_W'(i);
        if (PORT_ID_W'(i) > last_grant_q) begin
          pick_hi  = PORT_ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_XFER && eop_beat) last_grant_d = grant_q;
  end

  always_ff @(posedge m_aclk or posedge m_areset) begin
    if (m_areset) last_grant_q <= PORT_ID_W'(NUM_PORTS - 1);
    else          last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge m_aclk or posedge m_areset) begin
    if (m_areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = pick;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (eop_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are combinational from the registered grant, so reset clears them immediately.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_trdy   = '0;
    busy          = 1'b0;
    if (state_q == ST_XFER) begin
      busy = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (PORT_ID_W'(i) == grant_q) begin
          m_axis_tdata   = s_axis_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          m_axis_tvalid  = s_axis_tvalid[i];
          m_axis_tlast   = s_axis_tlast[i];
          s_axis_trdy[i] = m_axis_trdy;
        end
      end
    end
  end

  assign eop_beat = m_axis_tvalid & m_axis_trdy & m_axis_tlast;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: packet-level sources and sink, a grant-order model and a byte scoreboard.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;
  localparam int W  = 8;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*W-1:0] s_tdata;
  logic [NP-1:0]   s_tvalid, s_tlast, s_trdy;
  logic [W-1:0]    m_tdata;
  logic            m_tvalid, m_tlast, m_trdy;
  logic [0:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.AXI_DATA_WIDTH(W), .NUM_PORTS(NP)) dut (
    .m_aclk(clk), .m_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_trdy(m_trdy),
    .grant_id(grant_id), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Source beat entry: [7:0] data, [8] last, [15:9] idle cycles before the beat is offered.
  logic [15:0] srcq [NP][$];
  logic [W:0]  exp_q[$];
  logic [W:0]  rx_log[$];
  int          grant_log[$];
  int          model_last, model_g;
  bit          model_busy;
  int          src_gap_pct, trdy_low_pct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_winner(input logic [NP-1:0] req);
`ifdef AXIS_ARB_STRICT_PRIORITY_EN
    for (int p = 0; p < NP; p++) if (req[p]) return p;
`else
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (model_last + k) % NP;
      if (req[p]) return p;
    end
`endif
    return 0;
  endfunction

  function automatic bit any_src();
    for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_packet(input int p, input logic [7:0] base, input int len,
                             input int gap_at, input int gap_len);
    logic [15:0] e;
    for (int b = 0; b < len; b++) begin
      e[7:0]  = base + 8'(b);
      e[8]    = (b == len - 1);
      e[15:9] = (b == gap_at) ? 7'(gap_len) : 7'd0;
      srcq[p].push_back(e);
    end
  endtask

  task automatic load_expected(input int p);
    for (int i = 0; i < srcq[p].size(); i++) begin
      exp_q.push_back(srcq[p][i][8:0]);
      if (srcq[p][i][8]) break;
    end
  endtask

  task automatic drive(input logic [NP-1:0] acc);
    logic [15:0] e;
    bit held, v;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) void'(srcq[p].pop_front());
      held = s_tvalid[p] && !acc[p];
      v = 1'b0;
      if (srcq[p].size() != 0) begin
        e = srcq[p][0];
        if (held) v = 1'b1;
        else if (e[15:9] != 7'd0) begin
          e[15:9] = e[15:9] - 7'd1;
          srcq[p][0] = e;
        end else v = ($urandom_range(0, 99) >= src_gap_pct);
      end
      s_tvalid[p]       = v;
      s_tlast[p]        = v ? srcq[p][0][8] : 1'b0;
      s_tdata[p*W +: W] = v ? srcq[p][0][7:0] : '0;
    end
    m_trdy = ($urandom_range(0, 99) >= trdy_low_pct);
  endtask

  // One clock: check outputs mid-cycle, then advance model and sources past the edge.
  task automatic step();
    logic [NP-1:0] req, acc, exp_trdy;
    bit xfer, xlast, sv;
    @(negedge clk);
    req = s_tvalid;
    acc = '0;
    xfer = 1'b0;
    xlast = 1'b0;
    chk("busy", busy, model_busy);
    chk("grant_id", grant_id, model_g);
    if (model_busy) begin
      sv = s_tvalid[model_g];
      exp_trdy = '0;
      exp_trdy[model_g] = m_trdy;
      chk("m_tvalid", m_tvalid, sv);
      chk("s_trdy", s_trdy, exp_trdy);
      if (sv) begin
        chk("exp_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("m_tdata", m_tdata, exp_q[0][W-1:0]);
          chk("m_tlast", m_tlast, exp_q[0][W]);
          if (m_trdy) begin
            xfer  = 1'b1;
            xlast = exp_q[0][W];
            acc[model_g] = 1'b1;
            rx_log.push_back({m_tlast, m_tdata});
            void'(exp_q.pop_front());
          end
        end
      end
    end else begin
      chk("idle_m_tvalid", m_tvalid, 0);
      chk("idle_m_tdata", m_tdata, 0);
      chk("idle_m_tlast", m_tlast, 0);
      chk("idle_s_trdy", s_trdy, 0);
    end
    @(posedge clk);
    #1;
    if (model_busy) begin
      if (xfer && xlast) begin
        model_busy = 1'b0;
        model_last = model_g;
      end
    end else if (|req) begin
      model_g    = next_winner(req);
      model_busy = 1'b1;
      load_expected(model_g);
      grant_log.push_back(model_g);
    end
    drive(acc);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((model_busy || any_src()) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 32'(model_busy || any_src()), 0);
    step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_s_trdy", s_trdy, 0);
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    for (int p = 0; p < NP; p++) srcq[p].delete();
    exp_q.delete();
    rx_log.delete();
    grant_log.delete();
    model_busy = 1'b0;
    model_last = NP - 1;
    model_g    = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_rx(input int off, input logic [7:0] base, input int len);
    logic [W:0] got;
    for (int i = 0; i < len; i++) begin
      got = (off + i < rx_log.size()) ? rx_log[off + i] : 'x;
      chk("rx_beat", got, {1'(i == len - 1), 8'(base + 8'(i))});
    end
  endtask

  task automatic chk_grant(input int idx, input int exp);
    chk("grant_order", (idx < grant_log.size()) ? grant_log[idx] : -1, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int total, pkts;
    int p, len;
    m_trdy = 1'b1;
    src_gap_pct  = 0;
    trdy_low_pct = 0;
    apply_reset();

    // Single 4-beat packet on port 0.
    push_packet(0, 8'hA1, 4, -1, 0);
    drain(100);
    chk("t1_rx_count", rx_log.size(), 4);
    chk_rx(0, 8'hA1, 4);
    chk_grant(0, 0);

    // Two ports requesting together, two packets each.
    apply_reset();
    push_packet(0, 8'h10, 3, -1, 0);
    push_packet(0, 8'h18, 3, -1, 0);
    push_packet(1, 8'h20, 3, -1, 0);
    push_packet(1, 8'h28, 3, -1, 0);
    drain(200);
    chk("t2_rx_count", rx_log.size(), 12);
`ifdef AXIS_ARB_STRICT_PRIORITY_EN
    chk_grant(0, 0); chk_grant(1, 0); chk_grant(2, 1); chk_grant(3, 1);
    chk_rx(0, 8'h10, 3); chk_rx(3, 8'h18, 3); chk_rx(6, 8'h20, 3); chk_rx(9, 8'h28, 3);
`else
    chk_grant(0, 0); chk_grant(1, 1); chk_grant(2, 0); chk_grant(3, 1);
    chk_rx(0, 8'h10, 3); chk_rx(3, 8'h20, 3); chk_rx(6, 8'h18, 3); chk_rx(9, 8'h28, 3);
`endif

    // Downstream backpressure about 1 cycle in 20.
    rx_log.delete();
    trdy_low_pct = 5;
    push_packet(0, 8'h30, 8, -1, 0);
    drain(300);
    trdy_low_pct = 0;
    chk("t3_rx_count", rx_log.size(), 8);
    chk_rx(0, 8'h30, 8);

    // Port 1 pauses 5 cycles mid-packet while port 0 waits.
    rx_log.delete();
    grant_log.delete();
    push_packet(1, 8'h40, 4, 2, 5);
    step();
    push_packet(0, 8'h50, 3, -1, 0);
    drain(200);
    chk_grant(0, 1);
    chk_grant(1, 0);
    chk_rx(0, 8'h40, 4);
    chk_rx(4, 8'h50, 3);

    // Reset after beat 2 of a 5-beat packet, then check arbitration restarts cleanly.
    rx_log.delete();
    push_packet(0, 8'h90, 5, -1, 0);
    for (int n = 0; n < 50 && rx_log.size() < 2; n++) step();
    chk("t5_beats_before_reset", rx_log.size(), 2);
    #2;
    apply_reset();
    push_packet(1, 8'h60, 2, -1, 0);
    drain(100);
    push_packet(0, 8'h70, 2, -1, 0);
    push_packet(1, 8'h80, 2, -1, 0);
    drain(100);
    chk_grant(0, 1);
    chk_grant(1, 0);
    chk_grant(2, 1);
    chk_rx(0, 8'h60, 2);
    chk_rx(2, 8'h70, 2);
    chk_rx(4, 8'h80, 2);

    // Random traffic on both ports with source gaps and downstream stalls.
    rx_log.delete();
    src_gap_pct  = 20;
    trdy_low_pct = 30;
    total = 0;
    pkts  = 0;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        p   = $urandom_range(0, NP - 1);
        len = $urandom_range(1, 6);
        push_packet(p, 8'($urandom), len, -1, 0);
        total += len;
        pkts++;
      end
      drain(500);
    end
    chk("t6_rx_count", rx_log.size(), total);
    chk("t6_exp_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
